mc_main_control: RTL and testbench
==================================

# mc_main_control

Main control state machine for the multi-cycle MIPS core. It sequences every shared datapath resource (PC update unit, instruction register, register file, ALU operand muxes, unified memory) through fetch, decode and execute steps. It decodes the 6-bit opcode held in the instruction register, handshakes with memory through `mem_ready`, and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: instruction-register bits [31:26]; stable from DECODE until the instruction retires.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `iord` out 1: address mux select, 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the instruction register.
- `reg_dst` out 1: write-register select, 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-data select, 0 = ALUOut, 1 = MDR.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 1: ALU A select, 0 = PC, 1 = A register.
- `alu_src_b` out 2: ALU B select, 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = decode funct.
- `pc_write` out 1: unconditional PC write.
- `pc_write_cond` out 1: PC write when ALU zero is set.
- `pc_src` out 2: PC source, 00 = live ALU result, 01 = ALUOut, 10 = jump address.
- `state` out 4: current state code.
- `illegal` out 1: unsupported opcode trapped.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010. addi 001000 is supported only when the configuration macro is defined.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, HALT 15.
- Every output not listed for a state is 0.
- FETCH:
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write` and `pc_write` equal `mem_ready` (Mealy outputs).
  - Stay in FETCH until `mem_ready`, then go to DECODE.
- DECODE:
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut).
  - Next state: lw/sw → MEMADR, R-type → EXEC, beq → BRANCH, j → JUMP, addi → ADDI_EXEC (macro defined), anything else → HALT.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `iord`=1. Stay until `mem_ready`, then go to MEMWB.
- MEMWB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1. Next is FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Stay until `mem_ready`, then go to FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next is ALUWB.
- ALUWB: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1. Next is FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_src`=01. Next is FETCH.
- JUMP: `pc_write`=1, `pc_src`=10. Next is FETCH.
- HALT: `illegal`=1 and all strobes 0. The block stays in HALT until reset.
- Unused codes 12–14: next state is FETCH and all outputs are 0.
- `instr_count`:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDI_WB.
  - Wraps modulo 2^CNT_W.
  - Does not increment on entry to HALT.

## Timing
- While `reset`=1:
  - `state`=FETCH, `instr_count`=0, `illegal`=0.
  - All strobes are forced to 0, including `mem_read`, `pc_write` and `ir_write`.
- The first fetch strobe is asserted in the first cycle after reset deasserts.
- Cycles per instruction with zero memory wait: lw 5, sw 4, R-type 4, beq 3, j 3, addi 4.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds one cycle. Outputs stay constant during the wait.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
- Reset mid-instruction:
  - Returns to FETCH immediately (asynchronous).
  - Drops any pending memory strobe in the same cycle.
  - Clears `instr_count`.

## Configuration
- `MC_CTRL_ADDI_EN` defined:
  - addi decodes to ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Then ADDI_WB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1.
  - Then FETCH.
- `MC_CTRL_ADDI_EN` undefined:
  - States 10 and 11 are not built.
  - addi goes to HALT and raises `illegal`.

## Test plan
- Reset, then opcode 100011 with `mem_ready` tied to 1:
  - States 0,1,2,3,4,0.
  - `reg_write`=1 and `mem_to_reg`=1 only in state 4.
  - `instr_count` goes 0 → 1.
- sw with `mem_ready` low for 3 cycles in MEMWR: `mem_write`=1 and `iord`=1 for exactly 4 cycles, then FETCH.
- beq: `pc_write_cond`=1 and `pc_src`=01 in the single BRANCH cycle. j: `pc_write`=1 and `pc_src`=10 in JUMP. Each takes 3 cycles.
- FETCH with `mem_ready` low for 2 cycles: `ir_write`=0 and `pc_write`=0 in those cycles, then both 1 for one cycle.
- Opcode 111111: DECODE → HALT. `illegal`=1 and remains held; `instr_count` is unchanged. Asserting `reset` returns to FETCH with `illegal`=0.
- Opcode 001000:
  - Macro defined: states 0,1,10,11,0.
  - Macro undefined: HALT.
  - With `CNT_W`=2, four retirements wrap `instr_count` to 0.

Source files
------------

// File: rtl/mc_main_control_if.sv
// Control bundle between the multi-cycle main controller (master) and the datapath (slave).
interface mc_main_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_src;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_src,
           state, illegal, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_src,
           state, illegal, instr_count
  );
endinterface

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM with retired-instruction counter; Moore outputs registered from next state.
// addi support (states 10/11) is built only when MC_CTRL_ADDI_EN is defined.
module mc_main_control #(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  mc_main_control_if.master ctl
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMRD     = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWR     = 4'd5,
    S_EXEC      = 4'd6,
    S_ALUWB     = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
`ifdef MC_CTRL_ADDI_EN
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
`endif
    S_HALT      = 4'd15
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       illegal;
  } ctl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  function automatic state_t next_state(state_t s, logic [5:0] op, logic rdy);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = S_EXEC;
          OP_BEQ:       n = S_BRANCH;
          OP_J:         n = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      n = S_ADDI_EXEC;
`endif
          default:      n = S_HALT;
        endcase
      end
      S_MEMADR:    n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:     n = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:     n = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:      n = S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EXEC: n = S_ADDI_WB;
`endif
      S_HALT:      n = S_HALT;
      default:     n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'b01;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDI_WB: c.reg_write = 1'b1;
`endif
      S_HALT:  c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Last-step states: leaving one of these for FETCH retires an instruction.
  function automatic logic is_last_step(state_t s);
    logic r;
    case (s)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP: r = 1'b1;
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_WB: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_q;
  ctl_t             ctl_q;
  logic [CNT_W-1:0] count_q;
  state_t           nxt;
  logic             retire;
  logic             fetch_rdy;

  assign nxt    = next_state(state_q, ctl.opcode, ctl.mem_ready);
  assign retire = is_last_step(state_q) && (nxt == S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctl_q   <= decode(S_FETCH);
      count_q <= '0;
    end else begin
      state_q <= nxt;
      ctl_q   <= decode(nxt);
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  // Strobes are gated by reset so a pending access drops the instant reset rises.
  assign fetch_rdy         = (state_q == S_FETCH) & ctl.mem_ready;
  assign ctl.mem_read      = ctl_q.mem_read & ~reset;
  assign ctl.mem_write     = ctl_q.mem_write & ~reset;
  assign ctl.ir_write      = fetch_rdy & ~reset;
  assign ctl.pc_write      = (ctl_q.pc_write | fetch_rdy) & ~reset;
  assign ctl.pc_write_cond = ctl_q.pc_write_cond & ~reset;
  assign ctl.reg_write     = ctl_q.reg_write & ~reset;
  assign ctl.iord          = ctl_q.iord;
  assign ctl.reg_dst       = ctl_q.reg_dst;
  assign ctl.mem_to_reg    = ctl_q.mem_to_reg;
  assign ctl.alu_src_a     = ctl_q.alu_src_a;
  assign ctl.alu_src_b     = ctl_q.alu_src_b;
  assign ctl.alu_op        = ctl_q.alu_op;
  assign ctl.pc_src        = ctl_q.pc_src;
  assign ctl.illegal       = ctl_q.illegal;
  assign ctl.state         = state_q;
  assign ctl.instr_count   = count_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Randomised instruction stream against a per-instruction step-sequence model; a 2-bit-counter copy checks wrap.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  int         errors = 0;
  int         checks = 0;
  int         model_count = 0;

  localparam logic [16:0] STROBES = 17'b11010010000011000;
  localparam logic [5:0]  OP_R    = 6'b000000;
  localparam logic [5:0]  OP_LW   = 6'b100011;
  localparam logic [5:0]  OP_SW   = 6'b101011;
  localparam logic [5:0]  OP_BEQ  = 6'b000100;
  localparam logic [5:0]  OP_J    = 6'b000010;
  localparam logic [5:0]  OP_ADDI = 6'b001000;
  localparam logic [5:0]  OP_BAD  = 6'b111111;

  always #5 clk = ~clk;

  mc_main_control_if #(.CNT_W(32)) bus_a ();
  mc_main_control_if #(.CNT_W(2))  bus_b ();

  assign bus_a.opcode    = opcode;
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.opcode    = opcode;
  assign bus_b.mem_ready = mem_ready;

  mc_main_control #(.CNT_W(32)) dut_a (.clk(clk), .reset(reset), .ctl(bus_a.master));
  mc_main_control #(.CNT_W(2))  dut_b (.clk(clk), .reset(reset), .ctl(bus_b.master));

  logic [16:0] obs_a, obs_b;
  assign obs_a = {bus_a.mem_read, bus_a.mem_write, bus_a.iord, bus_a.ir_write, bus_a.reg_dst,
                  bus_a.mem_to_reg, bus_a.reg_write, bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op,
                  bus_a.pc_write, bus_a.pc_write_cond, bus_a.pc_src, bus_a.illegal};
  assign obs_b = {bus_b.mem_read, bus_b.mem_write, bus_b.iord, bus_b.ir_write, bus_b.reg_dst,
                  bus_b.mem_to_reg, bus_b.reg_write, bus_b.alu_src_a, bus_b.alu_src_b, bus_b.alu_op,
                  bus_b.pc_write, bus_b.pc_write_cond, bus_b.pc_src, bus_b.illegal};

  // Output table straight from the per-step descriptions, same bit order as obs_a.
  function automatic logic [16:0] expect_out(int s, logic rdy);
    logic mr, mw, io, irw, rd, m2r, rw, sa, pw, pwc, ill;
    logic [1:0] sb, op, ps;
    {mr, mw, io, irw, rd, m2r, rw, sa, pw, pwc, ill} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (s)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      15: ill = 1;
      default: ;
    endcase
    return {mr, mw, io, irw, rd, m2r, rw, sa, sb, op, pw, pwc, ps, ill};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive mem_ready, compare both DUTs, advance to just after the next edge.
  task automatic cycle(input int s, input logic rdy);
    mem_ready = rdy;
    #2;
    check($sformatf("state_a(s%0d)", s), 32'(bus_a.state), 32'(s));
    check($sformatf("outputs_a(s%0d)", s), 32'(obs_a), 32'(expect_out(s, rdy)));
    check($sformatf("count_a(s%0d)", s), bus_a.instr_count, 32'(model_count));
    check($sformatf("state_b(s%0d)", s), 32'(bus_b.state), 32'(s));
    check($sformatf("outputs_b(s%0d)", s), 32'(obs_b), 32'(expect_out(s, rdy)));
    check($sformatf("count_b(s%0d)", s), 32'(bus_b.instr_count), 32'(model_count % 4));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_count = 0;
    check("reset_state", 32'(bus_a.state), 32'd0);
    check("reset_count", bus_a.instr_count, 32'd0);
    check("reset_illegal", 32'(bus_a.illegal), 32'd0);
    check("reset_strobes", 32'(obs_a & STROBES), 32'd0);
    check("reset_count_b", 32'(bus_b.instr_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    opcode = op;
    repeat (fw) cycle(0, 1'b0);
    cycle(0, 1'b1);
    cycle(1, rbit());
    if (op == OP_LW) begin
      cycle(2, rbit());
      repeat (mw) cycle(3, 1'b0);
      cycle(3, 1'b1);
      cycle(4, rbit());
      model_count++;
    end else if (op == OP_SW) begin
      cycle(2, rbit());
      repeat (mw) cycle(5, 1'b0);
      cycle(5, 1'b1);
      model_count++;
    end else if (op == OP_R) begin
      cycle(6, rbit());
      cycle(7, rbit());
      model_count++;
    end else if (op == OP_BEQ) begin
      cycle(8, rbit());
      model_count++;
    end else if (op == OP_J) begin
      cycle(9, rbit());
      model_count++;
`ifdef MC_CTRL_ADDI_EN
    end else if (op == OP_ADDI) begin
      cycle(10, rbit());
      cycle(11, rbit());
      model_count++;
`endif
    end else begin
      repeat (4) cycle(15, rbit());
      do_reset();
    end
  endtask

  logic [5:0] ops [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BAD};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 3);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_R, 2, 0);
    run_instr(OP_ADDI, 0, 0);

    for (int i = 0; i < 120; i++) begin
      int k;
      k = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 5));
      run_instr(ops[k], int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Reset while a memory read is pending.
    opcode = OP_LW;
    cycle(0, 1'b1);
    cycle(1, 1'b0);
    cycle(2, 1'b0);
    cycle(3, 1'b0);
    do_reset();

    run_instr(OP_BAD, 1, 0);
    run_instr(OP_J, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
